// File: rtl/demux_1_8_packer.sv
// demux_1_8_packer: steers lane-tagged bytes into a 64-bit assembly word.
// A word is presented on a valid/ready output once every lane is written,
// or earlier on a flush. Unwritten lanes read as zero.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   byte offered
//   in_ready   block accepts the byte this cycle (registered)
//   in_sel     destination lane index
//   in_data    byte payload
//   flush      emit the partial word (honoured only while filling)
//   out_valid  assembled word available (registered)
//   out_ready  consumer takes the word
//   out_data   assembled word, lane k at [k*LANE_W +: LANE_W]
//   out_mask   bit k set when lane k was written
module demux_1_8_packer #(
  parameter int unsigned LANE_W = 8,
  parameter int unsigned LANES  = 8,
  parameter int unsigned SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [LANE_W-1:0]       in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANE_W*LANES-1:0] out_data,
  output logic [LANES-1:0]        out_mask
);

  localparam int unsigned WORD_W = LANE_W * LANES;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              r_state;
  logic [WORD_W-1:0]   r_lanes;
  logic [LANES-1:0]    r_mask;
  logic                r_in_ready;
  logic                r_out_valid;

  state_t              w_state_nxt;
  logic [WORD_W-1:0]   w_lanes_nxt;
  logic [LANES-1:0]    w_mask_nxt;
  logic                w_in_ready_nxt;
  logic                w_out_valid_nxt;
  logic                w_accept;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FILL;
      r_lanes     <= '0;
      r_mask      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lanes     <= w_lanes_nxt;
      r_mask      <= w_mask_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Next-state, lane write and handshake outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_lanes_nxt     = r_lanes;
    w_mask_nxt      = r_mask;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_accept        = 1'b0;

    case (r_state)
      FILL: begin
        w_accept = in_valid && r_in_ready;
        for (int unsigned k = 0; k < LANES; k++) begin
          if (w_accept && (in_sel == SEL_W'(k))) begin
            w_lanes_nxt[k*LANE_W +: LANE_W] = in_data;
            w_mask_nxt[k]                   = 1'b1;
          end
        end
        // Decision uses the post-accept mask so a same-cycle byte is included
        if ((&w_mask_nxt) || (flush && (|w_mask_nxt))) begin
          w_state_nxt     = HOLD;
          w_in_ready_nxt  = 1'b0;
          w_out_valid_nxt = 1'b1;
        end
      end
      HOLD: begin
        // Clearing on emission makes unwritten lanes of the next word read 0
        if (out_ready) begin
          w_state_nxt     = FILL;
          w_lanes_nxt     = '0;
          w_mask_nxt      = '0;
          w_in_ready_nxt  = 1'b1;
          w_out_valid_nxt = 1'b0;
        end
      end
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_lanes;
  assign out_mask  = r_mask;

endmodule

// File: tb/tb_demux_1_8_packer.sv
// Directed table-driven bench for demux_1_8_packer plus hand-written
// sequences for back-pressure and reset corner cases.
module tb_demux_1_8_packer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic [7:0]  in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_mask;

  int checks;
  int errors;

  demux_1_8_packer #(.LANE_W(8), .LANES(8), .SEL_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [2:0]  sel;
    logic [7:0]  data;
    logic        fl;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [63:0] e_data;
    logic [7:0]  e_mask;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic r, input logic v, input logic [2:0] s,
                              input logic [7:0] d, input logic f, input logic o,
                              input logic er, input logic eov,
                              input logic [63:0] ed, input logic [7:0] em);
    vec_t x;
    x.rst = r; x.vld = v; x.sel = s; x.data = d; x.fl = f; x.ordy = o;
    x.e_rdy = er; x.e_ov = eov; x.e_data = ed; x.e_mask = em;
    vt.push_back(x);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 ns after the edge
  task automatic step(input logic r, input logic v, input logic [2:0] s,
                      input logic [7:0] d, input logic f, input logic o);
    rst = r; in_valid = v; in_sel = s; in_data = d; flush = f; out_ready = o;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic er, input logic eov,
                            input logic [63:0] ed, input logic [7:0] em);
    check({tag, " in_ready"},  64'(in_ready),  64'(er));
    check({tag, " out_valid"}, 64'(out_valid), 64'(eov));
    check({tag, " out_data"},  out_data,       ed);
    check({tag, " out_mask"},  64'(out_mask),  64'(em));
  endtask

  logic [63:0] exp_word;
  logic [7:0]  exp_mask;
  logic [63:0] held_word;
  logic [2:0]  order [8];

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset, then in-order fill of lanes 0..7 with out_ready high
    add(1,0,0,8'h00,0,0, 1,0,64'h0,8'h00);
    add(0,1,0,8'h00,0,1, 1,0,64'h0,8'h01);
    add(0,1,1,8'h11,0,1, 1,0,64'h1100,8'h03);
    add(0,1,2,8'h22,0,1, 1,0,64'h221100,8'h07);
    add(0,1,3,8'h33,0,1, 1,0,64'h33221100,8'h0F);
    add(0,1,4,8'h44,0,1, 1,0,64'h4433221100,8'h1F);
    add(0,1,5,8'h55,0,1, 1,0,64'h554433221100,8'h3F);
    add(0,1,6,8'h66,0,1, 1,0,64'h66554433221100,8'h7F);
    add(0,1,7,8'h77,0,1, 0,1,64'h7766554433221100,8'hFF);
    add(0,0,0,8'h00,0,1, 1,0,64'h0,8'h00);
    // Partial fill and flush
    add(0,1,2,8'h5A,0,0, 1,0,64'h5A0000,8'h04);
    add(0,1,6,8'hC3,0,0, 1,0,64'h00C3_0000_005A_0000,8'h44);
    add(0,0,0,8'h00,1,0, 0,1,64'h00C3_0000_005A_0000,8'h44);
    add(0,0,0,8'h00,0,1, 1,0,64'h0,8'h00);
    // Flush on empty mask is ignored
    add(0,0,0,8'h00,1,0, 1,0,64'h0,8'h00);
    // Same-cycle accept and flush; HOLD ignores in_valid/flush
    add(0,1,1,8'hEE,1,0, 0,1,64'hEE00,8'h02);
    add(0,1,3,8'h99,1,0, 0,1,64'hEE00,8'h02);
    add(0,0,0,8'h00,0,1, 1,0,64'h0,8'h00);
    // Duplicate lane write: 9 accepts to emit
    add(0,1,0,8'h12,0,0, 1,0,64'h12,8'h01);
    add(0,1,0,8'h34,0,0, 1,0,64'h34,8'h01);
    add(0,1,1,8'hFF,0,0, 1,0,64'hFF34,8'h03);
    add(0,1,2,8'hFF,0,0, 1,0,64'hFFFF34,8'h07);
    add(0,1,3,8'hFF,0,0, 1,0,64'hFFFFFF34,8'h0F);
    add(0,1,4,8'hFF,0,0, 1,0,64'hFFFFFFFF34,8'h1F);
    add(0,1,5,8'hFF,0,0, 1,0,64'hFFFFFFFFFF34,8'h3F);
    add(0,1,6,8'hFF,0,0, 1,0,64'hFFFFFFFFFFFF34,8'h7F);
    add(0,1,7,8'hFF,0,0, 0,1,64'hFFFFFFFFFFFFFF34,8'hFF);
    add(0,0,0,8'h00,0,1, 1,0,64'h0,8'h00);
    // Reset during HOLD discards the word
    add(0,1,5,8'h55,1,0, 0,1,64'h0000_5500_0000_0000,8'h20);
    add(1,0,0,8'h00,0,1, 1,0,64'h0,8'h00);
    add(0,0,0,8'h00,0,1, 1,0,64'h0,8'h00);
    // Reset mid-fill: 8 fresh writes needed afterwards
    add(0,1,0,8'h01,0,0, 1,0,64'h01,8'h01);
    add(0,1,1,8'h02,0,0, 1,0,64'h0201,8'h03);
    add(1,1,2,8'h03,0,0, 1,0,64'h0,8'h00);
    add(0,1,1,8'hB1,0,0, 1,0,64'hB100,8'h02);
    add(0,1,2,8'hB2,0,0, 1,0,64'hB2B100,8'h06);
    add(0,1,3,8'hB3,0,0, 1,0,64'hB3B2B100,8'h0E);
    add(0,1,4,8'hB4,0,0, 1,0,64'hB4B3B2B100,8'h1E);
    add(0,1,5,8'hB5,0,0, 1,0,64'hB5B4B3B2B100,8'h3E);
    add(0,1,6,8'hB6,0,0, 1,0,64'hB6B5B4B3B2B100,8'h7E);
    add(0,1,7,8'hB7,0,0, 1,0,64'hB7B6B5B4B3B2B100,8'hFE);
    add(0,1,0,8'hB0,0,0, 0,1,64'hB7B6B5B4B3B2B1B0,8'hFF);
    add(0,0,0,8'h00,0,1, 1,0,64'h0,8'h00);

    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].vld, vt[i].sel, vt[i].data, vt[i].fl, vt[i].ordy);
      check_outs($sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_ov, vt[i].e_data, vt[i].e_mask);
    end

    // Out-of-order fill with 5 cycles of back-pressure
    order[0] = 3'd7; order[1] = 3'd3; order[2] = 3'd0; order[3] = 3'd5;
    order[4] = 3'd1; order[5] = 3'd6; order[6] = 3'd2; order[7] = 3'd4;
    exp_word = '0;
    exp_mask = '0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, order[i], 8'hA0 + 8'(order[i]), 0, 0);
      exp_word[order[i]*8 +: 8] = 8'hA0 + 8'(order[i]);
      exp_mask[order[i]] = 1'b1;
      check_outs($sformatf("ooo%0d", i), (i == 7) ? 1'b0 : 1'b1, (i == 7) ? 1'b1 : 1'b0,
                 exp_word, exp_mask);
    end
    check("ooo word", exp_word, 64'hA7A6A5A4A3A2A1A0);
    held_word = out_data;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 3'(i), 8'h5C, 1, 0);
      check_outs($sformatf("stall%0d", i), 1'b0, 1'b1, 64'hA7A6A5A4A3A2A1A0, 8'hFF);
      check($sformatf("stall%0d stable", i), out_data, held_word);
    end
    step(0, 0, 0, 8'h00, 0, 1);
    check_outs("release", 1'b1, 1'b0, 64'h0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux_1_8_packer.md
Name: demux_1_8_packer

Overview:
Inverse of the team's 8:1 byte-lane mux. It accepts one 8-bit byte per handshake, tagged with a 3-bit lane select, and steers it into that lane of a 64-bit assembly register. When all eight lanes are written, or on an explicit flush, it presents the assembled word with a lane-valid mask on a valid/ready output. It sits on the write side of the lane-select datapath, feeding 64-bit consumers.

Parameters:
LANE_W, 8, bits per lane
LANES, 8, number of lanes; the total word width is LANE_W*LANES
SEL_W, 3, lane select width; must equal clog2(LANES)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  byte offered
in_ready  output  1  block accepts the byte this cycle
in_sel  input  SEL_W  destination lane index
in_data  input  LANE_W  byte payload
flush  input  1  emit the partial word; sampled only when in FILL
out_valid  output  1  assembled word available
out_ready  input  1  consumer takes the word
out_data  output  LANE_W*LANES  assembled word; lane k occupies bits [k*LANE_W +: LANE_W]
out_mask  output  LANES  bit k set when lane k was written

Behaviour:
- Reset, synchronous, sampled on the clk rising edge when rst=1:
  - state=FILL, lane register=0, mask=0, out_valid=0, in_ready=1.
  - Reset wins over every other input. Reset during HOLD discards the pending word.
- Accept rule: a byte is accepted when in_valid && in_ready.
  - The byte is written to lane in_sel.
  - mask[in_sel] is set on the next edge.
- Duplicate lane write: the new byte overwrites the lane and the mask bit stays set. No error.
- State FILL:
  - in_ready=1, out_valid=0.
  - Go to HOLD when, after this cycle's accept, the mask is all ones (mask | onehot(in_sel) == all ones).
  - Also go to HOLD when flush=1 and the post-accept mask is non-zero.
    - A same-cycle accept and flush both take effect: the byte is included in the emitted word.
  - flush=1 with an empty mask and no accept is ignored and the block stays in FILL.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_data and out_mask are stable until the handshake.
  - Lanes not written read as 0 (they are cleared on emission).
  - On out_valid && out_ready: clear the lane register and mask, go to FILL.
    - in_ready returns to 1 on the following cycle. No same-cycle bypass.
  - flush and in_valid are ignored in HOLD.
- Latency:
  - The eighth distinct lane accepted at edge N gives out_valid=1 from cycle N+1.
  - Minimum period per full word: 8 accept cycles + 1 emit cycle.
- Outputs are registered. out_data is driven directly from the lane register.
- in_sel is always in range for LANES=8, so there is no default case.

Test Plan:
- Reset, then lanes 0..7 with bytes 0x00,0x11,...,0x77 and out_ready=1:
  - out_valid is high for exactly 1 cycle, starting one cycle after the eighth accept.
  - out_data=0x7766554433221100, out_mask=0xFF.
- Out-of-order fill (sel 7,3,0,5,1,6,2,4, data=0xA0+sel) with out_ready held low 5 cycles:
  - in_ready=0 and out_data stable throughout.
  - Word is 0xA7A6A5A4A3A2A1A0.
  - in_ready=1 one cycle after out_ready rises.
- Partial fill and flush: write lane2=0x5A, lane6=0xC3, then flush:
  - out_data=0x00C3_0000_005A_0000, out_mask=0x44.
  - The next word starts from an empty mask.
- Flush and accept in the same cycle (lane1=0xEE plus flush, nothing else written):
  - out_mask=0x02, out_data=0x000000000000EE00.
  - A flush with an empty mask and no accept produces no out_valid.
- Duplicate lane: lane0=0x12 then lane0=0x34, then lanes 1..7=0xFF:
  - out_data=0xFFFFFFFFFFFFFF34, and emission happens after 9 accepts.
- Reset mid-operation:
  - Assert rst in HOLD: out_valid=0 and in_ready=1 next cycle, and the old word is never delivered.
  - Assert rst mid-FILL: the mask is cleared, and 8 fresh writes are needed for emission.
